// File: rtl/regfile_wb_port.sv
// Integer register file with write-back port, two registered read ports and a pending-write scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle write-back data to the read ports.
module regfile_wb_port #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wbValid,
   input  logic [AW-1:0]   wbRd,
   input  logic [XLEN-1:0] wbData,
   input  logic            allocValid,
   input  logic [AW-1:0]   allocRd,
   input  logic            rdReq,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1Data,
   output logic [XLEN-1:0] rs2Data,
   output logic            rdDone,
   output logic            stall,
   output logic [AW:0]     pendCount
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pendingNext;
   logic [AW:0]      popNext;
   logic             wbEn;
   logic             allocEn;
   logic             hit1;
   logic             hit2;
   logic             haz1;
   logic             haz2;
   logic             accept;
   logic [XLEN-1:0]  val1;
   logic [XLEN-1:0]  val2;

   assign wbEn    = wbValid && (wbRd != '0);
   assign allocEn = allocValid && (allocRd != '0);

`ifdef REGFILE_WB_BYPASS_EN
   assign hit1 = wbEn && (wbRd == rs1);
   assign hit2 = wbEn && (wbRd == rs2);
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   // Hazard looks at pending before this cycle's allocation, so an
   // instruction never stalls on its own destination.
   assign haz1   = (rs1 != '0) && pending[rs1] && !hit1;
   assign haz2   = (rs2 != '0) && pending[rs2] && !hit2;
   assign stall  = rdReq && (haz1 || haz2);
   assign accept = rdReq && !stall;

   assign val1 = (rs1 == '0) ? '0 : (hit1 ? wbData : regs[rs1]);
   assign val2 = (rs2 == '0) ? '0 : (hit2 ? wbData : regs[rs2]);

   // Allocation is applied after the clear so the newer producer wins.
   always_comb begin
      pendingNext = pending;
      if (wbEn)
         pendingNext[wbRd] = 1'b0;
      if (allocEn)
         pendingNext[allocRd] = 1'b1;
      popNext = '0;
      for (int i = 0; i < NREGS; i++)
         popNext = popNext + {{AW{1'b0}}, pendingNext[i]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         pendCount <= '0;
      end else begin
         pending   <= pendingNext;
         pendCount <= popNext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wbEn) begin
         regs[wbRd] <= wbData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rs1Data <= '0;
         rs2Data <= '0;
         rdDone  <= 1'b0;
      end else begin
         rdDone <= accept;
         if (accept) begin
            rs1Data <= val1;
            rs2Data <= val2;
         end
      end
   end

endmodule

// File: doc/regfile_wb_port.md
Name: regfile_wb_port

Overview:
- Integer register file (x0..x31) on the consuming end of the write-back path.
- Accepts the selected write-back result (rd, data) and stores it.
- Serves two registered read ports to decode/issue.
- Keeps a pending-write scoreboard: a read whose source still awaits write-back is stalled instead of returning stale data.

Parameters:
- XLEN, 32, data width of every register and data port.
- NREGS, 32, number of architectural registers; x0 hardwired to zero.
- AW, 5, register index width; equals log2(NREGS).

Ports:
- clk  input  1  processor main clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wbValid  input  1  write-back strobe for this cycle.
- wbRd  input  AW  destination register of the write-back.
- wbData  input  XLEN  write-back data (output of the write-back selector).
- allocValid  input  1  issuing instruction will write allocRd later.
- allocRd  input  AW  register to mark pending.
- rdReq  input  1  read request from decode.
- rs1  input  AW  source register 1.
- rs2  input  AW  source register 2.
- rs1Data  output  XLEN  registered read data for rs1.
- rs2Data  output  XLEN  registered read data for rs2.
- rdDone  output  1  one-cycle pulse: rs1Data/rs2Data valid for the request accepted last cycle.
- stall  output  1  combinational: current rdReq not accepted; decode holds rs1/rs2.
- pendCount  output  AW+1  number of registers currently pending.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - All NREGS registers cleared to 0.
  - All pending bits cleared; pendCount=0.
  - rs1Data=rs2Data=0, rdDone=0.
  - wbValid, allocValid and rdReq are ignored in that cycle.
  - Reset mid-operation discards outstanding allocations; no write-back lands in that cycle.
- Write: wbValid=1 and wbRd!=0 → regs[wbRd]<=wbData and pending[wbRd]<=0 at the edge. wbRd=0 → no effect.
- Allocate: allocValid=1 and allocRd!=0 → pending[allocRd]<=1. allocRd=0 → ignored.
- Simultaneous alloc and write-back to the same rd: data is written; pending stays 1 (the newer producer wins).
- Hazard: hazN = (rsN!=0) && pending[rsN] && !bypassHitN, using pending as it stands before this cycle's alloc. stall = rdReq && (haz1 || haz2).
- Read accept (rdReq=1, stall=0):
  - Next edge: rsNData<=value(rsN), rdDone<=1.
  - Latency exactly 1 cycle.
  - x0 always reads 0.
- Not accepted (rdReq=0 or stall=1): rdDone<=0; rs1Data/rs2Data hold their previous values.
- Read source without the macro: a read in the same cycle as a write-back to that register returns the OLD array value, and the hazard stays asserted if the register is pending.
- pendCount: registered population count of the pending bits, updated in the same edge as the pending bits. Range 0..NREGS-1 (x0 never pending). Set and clear of different registers in one cycle → net count.
- Self-dependence: an instruction reading rs=rd while allocating rd in the same cycle is not stalled by its own allocation.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - bypassHitN = wbValid && wbRd!=0 && wbRd==rsN.
  - A hit returns wbData instead of the array value and suppresses hazN, so a pending source resolves in the write-back cycle itself.
- Undefined:
  - bypassHitN=0.
  - A hit returns the old value; a pending source stalls one extra cycle until pending clears.

Test Plan:
- Reset, then rdReq rs1=5 rs2=0 → next cycle rdDone=1, rs1Data=0, rs2Data=0, stall=0 throughout.
- wbValid wbRd=3 wbData=0xDEADBEEF; next cycle rdReq rs1=3 → rdDone=1, rs1Data=0xDEADBEEF. wbRd=0 wbData=0x1234 then read x0 → 0.
- allocValid allocRd=7; following cycles rdReq rs2=7 → stall=1, rdDone=0, pendCount=1. wbValid wbRd=7 wbData=0x55:
  - With bypass: stall=0 that cycle, next rs2Data=0x55.
  - Without bypass: stall=1 that cycle, stall=0 next cycle, rs2Data=0x55 one cycle later.
- Same cycle allocValid allocRd=9 and wbValid wbRd=9 wbData=0xA5 → pending[9] stays 1, pendCount unchanged by the pair, rdReq rs1=9 stalls; later wb 0x5A clears it and the read returns 0x5A.
- Allocate x1,x2,x3 (pendCount=3); assert rst for one cycle → pendCount=0, all regs 0, rdReq rs1=2 not stalled and returns 0.
- Same cycle rdReq rs1=4 with allocValid allocRd=4 and pending[4]=0 → stall=0, rs1Data=old x4; next rdReq rs1=4 → stall=1.
